// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle for alu_multicycle.
// master drives operands and consumes results; slave is the ALU.
interface alu_multicycle_if #(
  parameter int N = 8
);
  logic         in_valid_i;
  logic         in_ready_o;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic [3:0]   alucontrol;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [N-1:0] result;
  logic [3:0]   output_flags;
  logic         busy_o;

  modport master (
    output in_valid_i, a_i, b_i, alucontrol, out_ready_i,
    input  in_ready_o, out_valid_o, result, output_flags, busy_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, alucontrol, out_ready_i,
    output in_ready_o, out_valid_o, result, output_flags, busy_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// Sequential N-bit ALU: single-cycle arithmetic/logic, bit-serial shifts and
// shift-add multiply, with valid/ready handshakes and registered NZCV flags.
module alu_multicycle #(
  parameter int N = 8
) (
  input logic            clk_i,
  input logic            rst_ni,
  alu_multicycle_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] NMAX = N'(N);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SLA = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [3:0]    op;
  logic [CW-1:0] cnt;
  logic          sla_v;
  logic [N-1:0]  work;
  logic [N-1:0]  hi;
  logic [N-1:0]  mcand;

  logic          accept;
  logic [CW-1:0] amt;
  logic [N:0]    add_sum;
  logic [N:0]    sub_sum;
  logic [N-1:0]  imm_res;
  logic          imm_c;
  logic          imm_v;
  logic [N-1:0]  sh_next;
  logic          sh_out;
  logic          sh_v;
  logic [N:0]    mul_sum;
  logic [N-1:0]  mul_hi;
  logic [N-1:0]  mul_lo;

  function automatic logic [3:0] mk_flags(input logic [N-1:0] r, input logic c, input logic v);
    return {r[N-1], (r == '0), c, v};
  endfunction

  function automatic logic [CW-1:0] sat_amount(input logic [N-1:0] b);
    return (b >= NMAX) ? CW'(N) : b[CW-1:0];
  endfunction

  assign accept = bus.in_valid_i && bus.in_ready_o;
  assign amt    = sat_amount(bus.b_i);

  // Stage 0: single-cycle results from the live operands, used only at accept
  always_comb begin
    add_sum = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    sub_sum = {1'b0, bus.a_i} + {1'b0, ~bus.b_i} + (N+1)'(1);
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (bus.alucontrol)
      OP_ADD: begin
        imm_res = add_sum[N-1:0];
        imm_c   = add_sum[N];
        imm_v   = (bus.a_i[N-1] == bus.b_i[N-1]) && (add_sum[N-1] != bus.a_i[N-1]);
      end
      OP_SUB: begin
        imm_res = sub_sum[N-1:0];
        imm_c   = sub_sum[N];
        imm_v   = (bus.a_i[N-1] != bus.b_i[N-1]) && (sub_sum[N-1] != bus.a_i[N-1]);
      end
      OP_AND: imm_res = bus.a_i & bus.b_i;
      OP_OR:  imm_res = bus.a_i | bus.b_i;
      OP_NOT: imm_res = ~bus.a_i;
      OP_XOR: imm_res = bus.a_i ^ bus.b_i;
      // Zero-amount shifts bypass BUSY and return a unchanged
      OP_SLL, OP_SLA, OP_SRL, OP_SRA: imm_res = bus.a_i;
      default: imm_res = '0;
    endcase
  end

  // Stage 1: one iteration step of the held shift or multiply
  always_comb begin
    sh_next = work;
    sh_out  = 1'b0;
    sh_v    = 1'b0;
    case (op)
      OP_SLL, OP_SLA: begin
        sh_next = {work[N-2:0], 1'b0};
        sh_out  = work[N-1];
        sh_v    = (op == OP_SLA) && (work[N-1] != work[N-2]);
      end
      OP_SRL: begin
        sh_next = {1'b0, work[N-1:1]};
        sh_out  = work[0];
      end
      OP_SRA: begin
        sh_next = {work[N-1], work[N-1:1]};
        sh_out  = work[0];
      end
      default: ;
    endcase
    // {hi, work} shifts right each step; multiplier bits leave from work[0]
    mul_sum = {1'b0, hi} + (work[0] ? {1'b0, mcand} : '0);
    mul_hi  = mul_sum[N:1];
    mul_lo  = {mul_sum[0], work[N-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mcand <= bus.a_i;
      hi    <= '0;
      work  <= (bus.alucontrol == OP_MUL) ? bus.b_i : bus.a_i;
    end else if (state == BUSY) begin
      if (op == OP_MUL) begin
        work <= mul_lo;
        hi   <= mul_hi;
      end else begin
        work <= sh_next;
      end
    end
  end

  // Stage 2: control FSM with registered result, flags and handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      op               <= '0;
      cnt              <= '0;
      sla_v            <= 1'b0;
      bus.result       <= '0;
      bus.output_flags <= '0;
      bus.out_valid_o  <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.in_ready_o   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op             <= bus.alucontrol;
            sla_v          <= 1'b0;
            bus.in_ready_o <= 1'b0;
            bus.busy_o     <= 1'b1;
            if ((bus.alucontrol inside {OP_SLL, OP_SLA, OP_SRL, OP_SRA}) && (amt != '0)) begin
              cnt   <= amt;
              state <= BUSY;
            end else if (bus.alucontrol == OP_MUL) begin
              cnt   <= CW'(N);
              state <= BUSY;
            end else begin
              bus.result       <= imm_res;
              bus.output_flags <= mk_flags(imm_res, imm_c, imm_v);
              bus.out_valid_o  <= 1'b1;
              state            <= DONE;
            end
          end
        end
        BUSY: begin
          cnt   <= cnt - CW'(1);
          sla_v <= sla_v | sh_v;
          if (cnt == CW'(1)) begin
            bus.out_valid_o <= 1'b1;
            state           <= DONE;
            if (op == OP_MUL) begin
              bus.result       <= mul_lo;
              bus.output_flags <= mk_flags(mul_lo, |mul_hi, 1'b0);
            end else begin
              bus.result       <= sh_next;
              bus.output_flags <= mk_flags(sh_next, sh_out, sla_v | sh_v);
            end
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            bus.out_valid_o <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.in_ready_o  <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_multicycle;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_multicycle_if #(.N(N)) bus ();

  alu_multicycle #(.N(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: result, flags and latency derived directly from the opcode rules
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic [3:0] f, output int lat);
    logic [15:0] p;
    logic [7:0]  nb;
    logic [8:0]  aa;
    int sa, sb, s, k;
    logic c, v;
    c = 1'b0; v = 1'b0; lat = 1; r = 8'h00; p = 16'h0000;
    sa = int'($signed(a));
    sb = int'($signed(b));
    k  = (int'(b) > 8) ? 8 : int'(b);
    case (op)
      4'd0: begin
        p = 16'(a) + 16'(b); r = p[7:0]; c = p[8];
        s = sa + sb; v = (s > 127) || (s < -128);
      end
      4'd1: begin
        nb = ~b; p = 16'(a) + 16'(nb) + 16'd1; r = p[7:0]; c = p[8];
        s = sa - sb; v = (s > 127) || (s < -128);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: r = a ^ b;
      4'd6, 4'd7: begin
        p = 16'(a) << k; r = p[7:0]; c = (k > 0) ? p[8] : 1'b0; lat = 1 + k;
        if (op == 4'd7) begin
          aa = {a, 1'b0};
          for (int j = 1; j <= k; j++) if (aa[8-j] !== aa[8]) v = 1'b1;
        end
      end
      4'd8: begin
        p = {a, 8'h00} >> k; r = p[15:8]; c = (k > 0) ? p[7] : 1'b0; lat = 1 + k;
      end
      4'd9: begin
        s = sa >>> k; r = 8'(s);
        c = (k > 0) ? (((sa >>> (k - 1)) & 1) != 0) : 1'b0; lat = 1 + k;
      end
      4'd10: begin
        p = 16'(a) * 16'(b); r = p[7:0]; c = (p[15:8] != 8'h00); lat = 9;
      end
      default: r = 8'h00;
    endcase
    f = {r[7], (r == 8'h00), c, v};
  endfunction

  // Drives one transaction starting at a negedge and reports what was observed
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int stall, input bit poke,
                       output logic [7:0] res, output logic [3:0] flg, output int lat,
                       output bit busy_ok, output bit hold_ok, output bit ret_ok, output int waitc);
    waitc = 0;
    while (bus.in_ready_o !== 1'b1 && waitc < 200) begin
      @(negedge clk); waitc++;
    end
    bus.in_valid_i  = 1'b1;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.alucontrol  = op;
    bus.out_ready_i = (stall == 0);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.a_i        = 8'($urandom);
    bus.b_i        = 8'($urandom);
    bus.alucontrol = 4'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (bus.out_valid_o !== 1'b1 && lat < 100) begin
      if (bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b1) busy_ok = 1'b0;
      if (poke && lat == 1) begin
        bus.in_valid_i = 1'b1;
        bus.alucontrol = 4'd0;
      end else begin
        bus.in_valid_i = 1'b0;
      end
      @(negedge clk); lat++;
    end
    bus.in_valid_i = 1'b0;
    if (bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b1) busy_ok = 1'b0;
    res = bus.result;
    flg = bus.output_flags;
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b1 || bus.result !== res || bus.output_flags !== flg ||
          bus.in_ready_o !== 1'b0) hold_ok = 1'b0;
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    ret_ok = (bus.out_valid_o === 1'b0) && (bus.in_ready_o === 1'b1) && (bus.busy_o === 1'b0);
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL reset_result: got %h expected 00", bus.result); end
    checks++; if (bus.output_flags !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b expected 0000", bus.output_flags); end
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready_o); end
  endtask

  task automatic test_directed();
    logic [3:0] t_op [3] = '{4'd0, 4'd1, 4'd6};
    logic [7:0] t_a  [3] = '{8'h7F, 8'h05, 8'h81};
    logic [7:0] t_b  [3] = '{8'h01, 8'h05, 8'h14};
    logic [7:0] t_r  [3] = '{8'h80, 8'h00, 8'h00};
    logic [3:0] t_f  [3] = '{4'b1001, 4'b0110, 4'b0110};
    int         t_l  [3] = '{1, 1, 9};
    logic [7:0] res; logic [3:0] flg; int lat, waitc; bit busy_ok, hold_ok, ret_ok;
    for (int i = 0; i < 3; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 0, 1'b0, res, flg, lat, busy_ok, hold_ok, ret_ok, waitc);
      checks++; if (res !== t_r[i]) begin failures++; $display("FAIL directed%0d_result: got %h expected %h", i, res, t_r[i]); end
      checks++; if (flg !== t_f[i]) begin failures++; $display("FAIL directed%0d_flags: got %b expected %b", i, flg, t_f[i]); end
      checks++; if (lat !== t_l[i]) begin failures++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, t_l[i]); end
      checks++; if (ret_ok !== 1'b1) begin failures++; $display("FAIL directed%0d_return_idle: got %b expected 1", i, ret_ok); end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] res; logic [3:0] flg; int lat, waitc; bit busy_ok, hold_ok, ret_ok, extra;
    do_op(4'd9, 8'h90, 8'h03, 0, 1'b1, res, flg, lat, busy_ok, hold_ok, ret_ok, waitc);
    checks++; if (res !== 8'hF2) begin failures++; $display("FAIL sra_result: got %h expected f2", res); end
    checks++; if (flg !== 4'b1000) begin failures++; $display("FAIL sra_flags: got %b expected 1000", flg); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL sra_latency: got %0d expected 4", lat); end
    checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL sra_busy_in_ready: got %b expected 1", busy_ok); end
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin failures++; $display("FAIL busy_pulse_ignored: got %b expected 0", extra); end
  endtask

  task automatic test_stall();
    logic [7:0] res; logic [3:0] flg; int lat, waitc; bit busy_ok, hold_ok, ret_ok;
    do_op(4'd10, 8'h10, 8'h11, 3, 1'b0, res, flg, lat, busy_ok, hold_ok, ret_ok, waitc);
    checks++; if (res !== 8'h10) begin failures++; $display("FAIL mul_result: got %h expected 10", res); end
    checks++; if (flg !== 4'b0010) begin failures++; $display("FAIL mul_flags: got %b expected 0010", flg); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL mul_latency: got %0d expected 9", lat); end
    checks++; if (hold_ok !== 1'b1) begin failures++; $display("FAIL mul_stall_hold: got %b expected 1", hold_ok); end
    checks++; if (ret_ok !== 1'b1) begin failures++; $display("FAIL mul_return_idle: got %b expected 1", ret_ok); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] res; logic [3:0] flg; int lat, waitc; bit busy_ok, hold_ok, ret_ok;
    bus.in_valid_i = 1'b1; bus.a_i = 8'h33; bus.b_i = 8'h07; bus.alucontrol = 4'd10;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid_o); end
    checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL midrst_result: got %h expected 00", bus.result); end
    checks++; if (bus.output_flags !== 4'b0000) begin failures++; $display("FAIL midrst_flags: got %b expected 0000", bus.output_flags); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      failures++; $display("FAIL midrst_release: got ready=%b valid=%b expected ready=1 valid=0", bus.in_ready_o, bus.out_valid_o);
    end
    do_op(4'd12, 8'hA5, 8'h3C, 0, 1'b0, res, flg, lat, busy_ok, hold_ok, ret_ok, waitc);
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL reserved_result: got %h expected 00", res); end
    checks++; if (flg !== 4'b0100) begin failures++; $display("FAIL reserved_flags: got %b expected 0100", flg); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL reserved_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [7:0] a, b, res, er; logic [3:0] flg, ef;
    int lat, el, waitc, stall; bit busy_ok, hold_ok, ret_ok;
    for (int i = 0; i < 80; i++) begin
      op    = 4'($urandom_range(0, 15));
      a     = 8'($urandom);
      b     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      stall = $urandom_range(0, 2);
      model(op, a, b, er, ef, el);
      do_op(op, a, b, stall, 1'b0, res, flg, lat, busy_ok, hold_ok, ret_ok, waitc);
      checks++; if (res !== er) begin failures++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, er); end
      checks++; if (flg !== ef) begin failures++; $display("FAIL rand%0d_flags op=%0d a=%h b=%h: got %b expected %b", i, op, a, b, flg, ef); end
      checks++; if (lat !== el) begin failures++; $display("FAIL rand%0d_latency op=%0d b=%h: got %0d expected %0d", i, op, b, lat, el); end
      checks++; if (busy_ok !== 1'b1 || hold_ok !== 1'b1 || ret_ok !== 1'b1) begin
        failures++; $display("FAIL rand%0d_handshake: got busy=%b hold=%b ret=%b expected 111", i, busy_ok, hold_ok, ret_ok);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op; logic [7:0] a, b, res, er; logic [3:0] flg, ef;
    int lat, el, waitc; bit busy_ok, hold_ok, ret_ok;
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(0, 5));
      a  = 8'($urandom);
      b  = 8'($urandom);
      model(op, a, b, er, ef, el);
      do_op(op, a, b, 0, 1'b0, res, flg, lat, busy_ok, hold_ok, ret_ok, waitc);
      checks++; if (res !== er || flg !== ef) begin
        failures++; $display("FAIL b2b%0d_value op=%0d: got %h/%b expected %h/%b", i, op, res, flg, er, ef);
      end
      if (i > 0) begin
        checks++; if (waitc !== 0) begin failures++; $display("FAIL b2b%0d_throughput: got %0d wait cycles expected 0", i, waitc); end
      end
    end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.alucontrol  = '0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_stall();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised N-bit sequential ALU with registered operands, a valid/ready handshake on input and output, and registered NZCV flags.
- Keeps the existing 4-bit opcode map.
- Adds iterative shifters that shift one bit per cycle with a saturated amount.
- Adds a new iterative shift-add multiply (opcode 10).
- Sits between the operand/control path and the result/display path; upstream must wait on in_ready_o.

Parameters:
- N, 8, datapath width in bits; minimum 2.
- CW, $clog2(N+1), iteration counter width (derived; not overridden).

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  operands and opcode valid
- in_ready_o  output  1  block can accept (high only in IDLE)
- a_i  input  N  operand A
- b_i  input  N  operand B; for shifts, the unsigned shift amount
- alucontrol  input  4  opcode
- out_valid_o  output  1  result and flags valid
- out_ready_i  input  1  consumer takes result
- result  output  N  registered result
- output_flags  output  4  {N, Z, C, V} registered
- busy_o  output  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst_ni low):
  - State goes to IDLE.
  - result=0, output_flags=0, out_valid_o=0, busy_o=0, in_ready_o=1 (as soon as reset deasserts).
  - Reset mid-operation discards that operation.
- States: IDLE, BUSY, DONE.
- Accept: in_valid_i & in_ready_o at an edge latches a_i, b_i and alucontrol. Later input changes have no effect. in_valid_i outside IDLE is ignored (no queueing).
- Opcodes and latency (latency = edges from accept to out_valid_o high):
  - 0 ADD, 1 SUB (a + ~b + 1), 2 AND, 3 OR, 4 NOT a, 5 XOR: IDLE->DONE directly, latency 1.
  - 6 SLL, 7 SLA, 8 SRL, 9 SRA: k = min(b, N). One bit per BUSY cycle, latency 1+k. k=0 goes directly to DONE with result=a.
  - 10 MUL: unsigned shift-add over N BUSY cycles, latency N+1. result = low N bits of the 2N-bit product.
  - 11-15 reserved: result 0, latency 1.
- Flags:
  - N = result[N-1]; Z = (result == 0).
  - ADD/SUB: C = carry out (SUB: C=1 means no borrow); V = signed overflow.
  - Logic ops and reserved opcodes: C=0, V=0.
  - Shifts: C = last bit shifted out (0 if k=0).
  - SLA: result identical to SLL; V=1 if the sign bit changed at any step. Other shifts: V=0.
  - MUL: C=1 if the high N product bits are nonzero; V=0.
- DONE: out_valid_o=1; result and flags held stable until out_ready_i is high at an edge, then IDLE.
  - in_ready_o returns high the cycle after the output handshake; no same-cycle accept.
  - out_ready_i outside DONE has no effect.
- Minimum throughput: one operation per 2 cycles.

Test Plan:
- N=8, ADD a=0x7F b=0x01, out_ready_i=1 -> out_valid_o 1 cycle after accept, result 0x80, flags 1001; in_ready_o high again next cycle.
- SUB a=0x05 b=0x05 -> result 0x00, flags 0110 (Z=1, C=1 no borrow).
- SRA a=0x90 b=0x03 -> result 0xF2, flags 1000, latency 4. in_ready_o=0 throughout; an in_valid_i pulse with ADD during BUSY is ignored (no second result).
- SLL a=0x81 b=0x14 (saturates to 8) -> result 0x00, flags 0110 (C = original bit0 = 1), latency 9.
- MUL a=0x10 b=0x11 with out_ready_i held low 3 cycles after out_valid_o -> result 0x10, flags 0010, latency 9; result and flags unchanged while stalled.
- Assert rst_ni=0 mid-MUL (cycle 4) -> out_valid_o=0, result=0, flags 0000 immediately. After release: in_ready_o=1; reserved opcode 12 gives result 0x00, flags 0100, latency 1.
